pc_fetch: RTL

Instruction-fetch stage (IF) of the 5-stage MIPS pipeline; it is the producer end of the IF→ID bus and the consumer of the ID branch bus.
- Holds the PC and issues synchronous instruction-SRAM reads; the fetched word returns to ID one cycle later.
- Applies branch/jump redirects from ID, pipeline stalls and exception flushes.
- Buffers a redirect that arrives while IF is stalled, so no taken branch is lost.

---
 rtl/pc_fetch_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 25 ++
 rtl/pc_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared widths, stall encoding and state type for the instruction-fetch stage.
// The stall-stage encoding and bus widths match the rest of the pipeline.
package pc_fetch_pkg;

    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;
    localparam int STALL_BUS_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: flush target, then buffered redirect, then branch,
// then sequential fetch.
module pc_next_sel (
    input  logic        i_flush,
    input  logic [31:0] i_new_pc,
    input  logic        i_pend_v,
    input  logic [31:0] i_pend_addr,
    input  logic        i_br_e,
    input  logic [31:0] i_br_addr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc + 32'd4;
        if (i_flush) begin
            o_next_pc = i_new_pc;
        end else if (i_pend_v) begin
            o_next_pc = i_pend_addr;
        end else if (i_br_e) begin
            o_next_pc = i_br_addr;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// IF stage: owns the PC, issues instruction-SRAM reads and presents the
// {ce, pc} slot to ID. A branch seen while IF is stalled is held until release.
//
// state  | meaning
// S_BOOT | out of reset, nothing fetched yet (ce=0)
// S_RUN  | fetching, no redirect buffered
// S_HOLD | stalled with a branch target buffered in r_pend_addr
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          STALL_W  = STALL_BUS_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [STALL_W-1:0]     i_stall,
    input  logic                   i_flush,
    input  logic [31:0]            i_new_pc,
    input  logic [BR_WD-1:0]       i_br_bus,
    output logic [IF_TO_ID_WD-1:0] o_if_to_id_bus,
    output logic                   o_fetch_adel,
    output logic                   o_inst_sram_en,
    output logic [3:0]             o_inst_sram_wen,
    output logic [31:0]            o_inst_sram_addr,
    output logic [31:0]            o_inst_sram_wdata
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_pend_addr;
    logic [31:0]  w_pend_addr_nxt;
    logic [31:0]  w_next_pc;
    logic         w_ce;
    logic         w_pend_v;
    logic         w_br_e;
    logic [31:0]  w_br_addr;
    logic         w_stop;
    logic         w_aligned;
    logic         w_unused_stall;

    assign w_br_e         = i_br_bus[32];
    assign w_br_addr      = i_br_bus[31:0];
    assign w_stop         = (i_stall[0] == STOP);
    assign w_unused_stall = ^i_stall[STALL_W-1:1];
    assign w_ce           = (r_state != S_BOOT);
    assign w_pend_v       = (r_state == S_HOLD);
    assign w_aligned      = is_word_aligned(r_pc);

    pc_next_sel u_next_sel (
        .i_flush     (i_flush),
        .i_new_pc    (i_new_pc),
        .i_pend_v    (w_pend_v),
        .i_pend_addr (r_pend_addr),
        .i_br_e      (w_br_e),
        .i_br_addr   (w_br_addr),
        .i_pc        (r_pc),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC - 32'd4;
            r_pend_addr <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_addr_nxt = r_pend_addr;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
                w_pc_nxt    = RESET_PC;
            end
            default: begin
                if (i_flush) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = w_next_pc;
                end else if (w_stop) begin
                    // a newer branch while already holding replaces the old target
                    if (w_br_e) begin
                        w_state_nxt     = S_HOLD;
                        w_pend_addr_nxt = w_br_addr;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = w_next_pc;
                end
            end
        endcase
    end

    // read is re-issued every held cycle so a stalled ID keeps valid data
    assign o_inst_sram_en    = w_ce & w_aligned;
    assign o_fetch_adel      = w_ce & ~w_aligned;
    assign o_inst_sram_wen   = 4'b0000;
    assign o_inst_sram_addr  = r_pc;
    assign o_inst_sram_wdata = 32'h0;
    assign o_if_to_id_bus    = {w_ce, r_pc};

endmodule
